// File: rtl/typepkg.sv
// Shared pipeline types: LSU opcodes, FSM states and the error return value.
// Build option: LSU_MISALIGN_CHECK_EN enables misaligned-access errors.
package typepkg;

  localparam logic [31:0] BAD_VAL = 32'hBAD0_BAD0;

`ifdef LSU_MISALIGN_CHECK_EN
  localparam bit MISALIGN_CHK = 1'b1;
`else
  localparam bit MISALIGN_CHK = 1'b0;
`endif

  typedef enum logic [3:0] {
    OP_LB  = 4'h0,
    OP_LH  = 4'h1,
    OP_LW  = 4'h2,
    OP_LBU = 4'h4,
    OP_LHU = 4'h5,
    OP_SB  = 4'h8,
    OP_SH  = 4'h9,
    OP_SW  = 4'hA
  } lsu_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores, load extraction/extension and
// the illegal/misaligned flag. Purely combinational.
module lsu_align
  import typepkg::*;
(
  input  lsu_op_t     op,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        we,
  output logic [3:0]  wstrb,
  output logic [31:0] wlane,
  output logic [31:0] rext,
  output logic        bad
);

  logic [31:0] sb;
  logic [31:0] sh;
  logic [7:0]  b;
  logic [15:0] h;
  logic        ill;
  logic        mis;

  // Halves are always steered by off[1]; off[0] only matters for checking.
  assign sb = rdata >> {off, 3'b000};
  assign sh = rdata >> {off[1], 4'b0000};
  assign b  = sb[7:0];
  assign h  = sh[15:0];

  always_comb begin
    we    = 1'b0;
    wstrb = 4'b0000;
    wlane = wdata;
    rext  = rdata;
    ill   = 1'b0;
    mis   = 1'b0;
    unique case (op)
      OP_LB:  rext = {{24{b[7]}}, b};
      OP_LBU: rext = {24'h0, b};
      OP_LH: begin
        rext = {{16{h[15]}}, h};
        mis  = off[0];
      end
      OP_LHU: begin
        rext = {16'h0, h};
        mis  = off[0];
      end
      OP_LW: begin
        rext = rdata;
        mis  = |off;
      end
      OP_SB: begin
        we    = 1'b1;
        wstrb = 4'b0001 << off;
        wlane = {4{wdata[7:0]}};
      end
      OP_SH: begin
        we    = 1'b1;
        wstrb = 4'b0011 << {off[1], 1'b0};
        wlane = {2{wdata[15:0]}};
        mis   = off[0];
      end
      OP_SW: begin
        we    = 1'b1;
        wstrb = 4'b1111;
        mis   = |off;
      end
      default: ill = 1'b1;
    endcase
  end

  assign bad = ill | (mis & MISALIGN_CHK);

endmodule

// File: rtl/lsu.sv
// Memory stage: single-outstanding load/store sequencing to data memory.
// Build option: LSU_MISALIGN_CHECK_EN (see typepkg).
module lsu
  import typepkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  lsu_op_t         req_op,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [4:0]      req_rd,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_we,
  output logic [3:0]      mem_wstrb,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_data,
  output logic [4:0]      resp_rd,
  output logic            resp_err
);

  lsu_state_t state_q, state_d;
  lsu_op_t    op_q;
  logic [1:0] off_q;
  logic [3:0] wstrb_q;
  logic       we_q;
  logic       err_q;

  lsu_op_t     a_op;
  logic [1:0]  a_off;
  logic        a_we;
  logic [3:0]  a_wstrb;
  logic [31:0] a_wlane;
  logic [31:0] a_rext;
  logic        a_bad;

  logic accept;

  assign accept = (state_q == S_IDLE) && req_valid;

  // One decoder serves both the accept cycle and the later load return.
  assign a_op  = (state_q == S_IDLE) ? req_op : op_q;
  assign a_off = (state_q == S_IDLE) ? req_addr[1:0] : off_q;

  lsu_align u_align (
    .op    (a_op),
    .off   (a_off),
    .wdata (req_wdata),
    .rdata (mem_rdata),
    .we    (a_we),
    .wstrb (a_wstrb),
    .wlane (a_wlane),
    .rext  (a_rext),
    .bad   (a_bad)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (req_valid) state_d = a_bad ? S_RESP : S_REQ;
      S_REQ:  if (mem_ready) state_d = we_q ? S_RESP : S_WAIT;
      S_WAIT: if (mem_rvalid) state_d = S_RESP;
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= OP_LB;
      off_q     <= 2'b00;
      wstrb_q   <= 4'b0000;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      resp_data <= '0;
      resp_rd   <= 5'd0;
    end else begin
      if (accept) begin
        op_q      <= req_op;
        off_q     <= req_addr[1:0];
        wstrb_q   <= a_wstrb;
        we_q      <= a_we;
        err_q     <= a_bad;
        mem_addr  <= {req_addr[XLEN-1:2], 2'b00};
        mem_wdata <= a_wlane;
        resp_rd   <= req_rd;
        if (a_bad) resp_data <= BAD_VAL;
      end
      if (state_q == S_REQ && mem_ready && we_q)
        resp_data <= '0;
      if (state_q == S_WAIT && mem_rvalid)
        resp_data <= a_rext;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign mem_valid  = (state_q == S_REQ);
  assign mem_we     = mem_valid & we_q;
  assign mem_wstrb  = mem_valid ? wstrb_q : 4'b0000;
  assign resp_valid = (state_q == S_RESP);
  assign resp_err   = MISALIGN_CHK ? (resp_valid & err_q) : 1'b0;

endmodule

// File: tb/tb_lsu.sv
// Directed-vector bench for lsu: loads, stores, errors, stalls, reset.
module tb_lsu;
  import typepkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  lsu_op_t     req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        resp_err;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef LSU_MISALIGN_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  always #5 clk = ~clk;

  lsu dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_rd     (req_rd),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wstrb  (mem_wstrb),
    .mem_wdata  (mem_wdata),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_rd    (resp_rd),
    .resp_err   (resp_err)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input lsu_op_t op, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] rd);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = a;
    req_wdata = wd;
    req_rd    = rd;
    chk("accept_ready", req_ready, 1);
    tick;
    req_valid = 1'b0;
  endtask

  // Zero-wait load: mem_valid at N+1, rvalid at N+2, resp at N+3.
  task automatic do_load(input string tag, input lsu_op_t op,
                         input logic [31:0] a, input logic [31:0] rdata,
                         input logic [31:0] word, input logic [31:0] exp);
    offer(op, a, 32'h0, 5'd7);
    chk({tag, "_mvalid"}, mem_valid, 1);
    chk({tag, "_maddr"}, mem_addr, word);
    chk({tag, "_mwe"}, mem_we, 0);
    mem_ready = 1'b1;
    tick;
    mem_ready = 1'b0;
    chk({tag, "_n2_resp"}, resp_valid, 0);
    mem_rvalid = 1'b1;
    mem_rdata  = rdata;
    tick;
    mem_rvalid = 1'b0;
    chk({tag, "_resp"}, resp_valid, 1);
    chk({tag, "_data"}, resp_data, exp);
    chk({tag, "_err"}, resp_err, 0);
    chk({tag, "_rd"}, resp_rd, 32'd7);
    tick;
    chk({tag, "_idle"}, {31'd0, resp_valid}, 0);
  endtask

  task automatic do_store(input string tag, input lsu_op_t op,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] word, input logic [3:0] strb,
                          input logic [31:0] lane);
    offer(op, a, wd, 5'd3);
    chk({tag, "_mvalid"}, mem_valid, 1);
    chk({tag, "_maddr"}, mem_addr, word);
    chk({tag, "_mwe"}, mem_we, 1);
    chk({tag, "_strb"}, mem_wstrb, strb);
    chk({tag, "_wdata"}, mem_wdata, lane);
    mem_ready = 1'b1;
    tick;
    mem_ready = 1'b0;
    chk({tag, "_resp"}, resp_valid, 1);
    chk({tag, "_data"}, resp_data, 0);
    chk({tag, "_err"}, resp_err, 0);
    tick;
    chk({tag, "_idle"}, req_ready, 1);
  endtask

  task automatic do_err(input string tag, input lsu_op_t op,
                        input logic [31:0] a);
    offer(op, a, 32'h0, 5'd9);
    chk({tag, "_nomem"}, mem_valid, 0);
    chk({tag, "_resp"}, resp_valid, 1);
    chk({tag, "_data"}, resp_data, BAD_VAL);
    chk({tag, "_err"}, resp_err, {31'd0, EXP_ERR});
    chk({tag, "_rd"}, resp_rd, 32'd9);
    tick;
    chk({tag, "_idle"}, req_ready, 1);
    chk({tag, "_nomem2"}, mem_valid, 0);
  endtask

  initial begin
    int pulses;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_op     = OP_LB;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    req_rd     = 5'd0;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    tick;
    tick;
    rst = 1'b0;
    chk("rst_ready", req_ready, 1);
    chk("rst_mvalid", mem_valid, 0);
    chk("rst_mwe", mem_we, 0);
    chk("rst_strb", mem_wstrb, 0);
    chk("rst_maddr", mem_addr, 0);
    chk("rst_mwdata", mem_wdata, 0);
    chk("rst_rvalid", resp_valid, 0);
    chk("rst_rdata", resp_data, 0);
    chk("rst_rrd", resp_rd, 0);
    chk("rst_rerr", resp_err, 0);

    do_load("lw100", OP_LW, 32'h100, 32'hDEAD_BEEF, 32'h100, 32'hDEAD_BEEF);
    do_load("lb103", OP_LB, 32'h103, 32'h8011_2233, 32'h100, 32'hFFFF_FF80);
    do_load("lbu103", OP_LBU, 32'h103, 32'h8011_2233, 32'h100, 32'h0000_0080);
    do_load("lb101", OP_LB, 32'h101, 32'h8011_2233, 32'h100, 32'h0000_0022);
    do_load("lh102", OP_LH, 32'h102, 32'h8011_2233, 32'h100, 32'hFFFF_8011);
    do_load("lhu100", OP_LHU, 32'h100, 32'h8011_A233, 32'h100, 32'h0000_A233);
    do_store("sh202", OP_SH, 32'h202, 32'h0000_ABCD, 32'h200, 4'b1100,
             32'hABCD_ABCD);
    do_store("sb101", OP_SB, 32'h101, 32'h0000_0055, 32'h100, 4'b0010,
             32'h5555_5555);
    do_store("sw300", OP_SW, 32'h300, 32'h1234_5678, 32'h300, 4'b1111,
             32'h1234_5678);
    do_err("illegal", lsu_op_t'(4'h3), 32'h100);
`ifdef LSU_MISALIGN_CHECK_EN
    do_err("lw101", OP_LW, 32'h101);
    do_err("sh203", OP_SH, 32'h203);
`else
    do_load("lw101", OP_LW, 32'h101, 32'hCAFE_F00D, 32'h100, 32'hCAFE_F00D);
    do_store("sh203", OP_SH, 32'h203, 32'h0000_1357, 32'h200, 4'b1100,
             32'h1357_1357);
`endif

    // mem_ready held low 4 cycles, then rvalid 3 cycles late.
    offer(OP_LH, 32'h102, 32'h0, 5'd12);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      chk("stall_mvalid", mem_valid, 1);
      chk("stall_maddr", mem_addr, 32'h100);
      chk("stall_mwe", mem_we, 0);
      chk("stall_ready", req_ready, 0);
      if (resp_valid) pulses++;
      tick;
    end
    mem_ready = 1'b1;
    chk("stall_hs_mvalid", mem_valid, 1);
    tick;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("late_mvalid", mem_valid, 0);
      chk("late_ready", req_ready, 0);
      if (resp_valid) pulses++;
      tick;
    end
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h7FFF_0000;
    tick;
    mem_rvalid = 1'b0;
    chk("late_data", resp_data, 32'h0000_7FFF);
    chk("late_rd", resp_rd, 32'd12);
    for (int i = 0; i < 4; i++) begin
      if (resp_valid) pulses++;
      tick;
    end
    chk("late_pulses", pulses, 1);
    chk("late_idle", req_ready, 1);

    // Reset while in WAIT, then a stale rvalid.
    offer(OP_LW, 32'h100, 32'h0, 5'd5);
    mem_ready = 1'b1;
    tick;
    mem_ready = 1'b0;
    chk("rstw_inwait", mem_valid, 0);
    chk("rstw_busy", req_ready, 0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rstw_ready", req_ready, 1);
    chk("rstw_mvalid", mem_valid, 0);
    chk("rstw_resp", resp_valid, 0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1111_1111;
    tick;
    mem_rvalid = 1'b0;
    chk("rstw_stale_resp", resp_valid, 0);
    chk("rstw_stale_ready", req_ready, 1);
    tick;
    chk("rstw_stale_resp2", resp_valid, 0);
    chk("rstw_data", resp_data, 0);

    do_load("post_rst", OP_LBU, 32'h102, 32'h00AB_0000, 32'h100, 32'h0000_00AB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
